// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush enables, data-memory handshake, WB forwarding selects
// and a saturating stall-cycle counter for the IF/ID -> ID -> EXMEM -> WB pipeline.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_reg1,
  input  logic [4:0]       id_reg2,
  input  logic             id_branch_tkn,
  input  logic [4:0]       exmem_reg1,
  input  logic [4:0]       exmem_reg2,
  input  logic             exmem_mem_en,
  input  logic [4:0]       wb_Wreg,
  input  logic             wb_Wreg_en,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             exmem_en,
  output logic             wb_en,
  output logic             dmem_req,
  output logic             id_fwd1,
  output logic             id_fwd2,
  output logic             ex_fwd1,
  output logic             ex_fwd2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             ex_fwd1_q, ex_fwd1_d, ex_fwd2_q, ex_fwd2_d;
  logic             mem_err_q, mem_err_d;
  logic [4:0]       cap_wreg_q, cap_wreg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;
  always_comb begin
    stall = (state_q == RUN && exmem_mem_en && !dmem_ack) ||
            (state_q == MEM_WAIT && !dmem_ack) || state_q == ERR;
    dmem_req = (state_q == RUN && exmem_mem_en) || state_q == MEM_WAIT;
    pc_en = !stall;
    ifid_en = !stall;
    exmem_en = !stall;
    wb_en = !stall;
    ifid_flush = id_branch_tkn && !stall;
    id_fwd1 = wb_Wreg_en && wb_Wreg == id_reg1 && id_reg1 != 5'd0;
    id_fwd2 = wb_Wreg_en && wb_Wreg == id_reg2 && id_reg2 != 5'd0;
    state_d = state_q == RUN ? (exmem_mem_en && !dmem_ack ? MEM_WAIT : RUN) :
              state_q == MEM_WAIT ? (dmem_ack ? RUN : wait_q == WAIT_LAST ? ERR : MEM_WAIT) :
              ERR;
    wait_d = state_q == MEM_WAIT ? wait_q + 1'b1 : '0;
    mem_err_d = state_d == ERR;
    ex_fwd1_d = stall ? ex_fwd1_q : id_fwd1;
    ex_fwd2_d = stall ? ex_fwd2_q : id_fwd2;
    cap_wreg_d = stall ? cap_wreg_q : wb_Wreg;
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    ex_fwd1 = ex_fwd1_q;
    ex_fwd2 = ex_fwd2_q;
    mem_err = mem_err_q;
    stall_cnt = stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q <= '0;
      ex_fwd1_q <= 1'b0;
      ex_fwd2_q <= 1'b0;
      mem_err_q <= 1'b0;
      cap_wreg_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      ex_fwd1_q <= ex_fwd1_d;
      ex_fwd2_q <= ex_fwd2_d;
      mem_err_q <= mem_err_d;
      cap_wreg_q <= cap_wreg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  // A forward select in EXMEM must name the register the WB producer wrote when it was captured.
  a_ex_fwd1: assert property (@(posedge clk) disable iff (!rst) ex_fwd1_q |-> exmem_reg1 == cap_wreg_q);
  a_ex_fwd2: assert property (@(posedge clk) disable iff (!rst) ex_fwd2_q |-> exmem_reg2 == cap_wreg_q);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_reg1 = '0, id_reg2 = '0, exmem_reg1 = '0, exmem_reg2 = '0, wb_Wreg = '0;
  logic id_branch_tkn = 1'b0, exmem_mem_en = 1'b0, wb_Wreg_en = 1'b0, dmem_ack = 1'b0;
  logic pc_en, ifid_en, ifid_flush, exmem_en, wb_en, dmem_req;
  logic id_fwd1, id_fwd2, ex_fwd1, ex_fwd2, mem_err;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_branch_tkn(id_branch_tkn),
    .exmem_reg1(exmem_reg1), .exmem_reg2(exmem_reg2), .exmem_mem_en(exmem_mem_en),
    .wb_Wreg(wb_Wreg), .wb_Wreg_en(wb_Wreg_en), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .exmem_en(exmem_en),
    .wb_en(wb_en), .dmem_req(dmem_req), .id_fwd1(id_fwd1), .id_fwd2(id_fwd2),
    .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit m_err, m_busy, m_x1, m_x2;
  int m_age, m_cnt;
  logic [14:0] act_v, exp_v;

  typedef struct {
    logic [4:0] r1, r2, wr;
    logic we, br, mem, ack;
    logic st, req, fl, f1, f2, x1, x2, er;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [14:0] outs();
    return {pc_en, ifid_en, exmem_en, wb_en, dmem_req, ifid_flush,
            id_fwd1, id_fwd2, ex_fwd1, ex_fwd2, mem_err, stall_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_busy = 0; m_x1 = 0; m_x2 = 0; m_age = 0; m_cnt = 0;
  endtask

  task automatic zero_inputs();
    id_reg1 = '0; id_reg2 = '0; wb_Wreg = '0; wb_Wreg_en = 0;
    id_branch_tkn = 0; exmem_mem_en = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    zero_inputs();
    exmem_reg1 = '0; exmem_reg2 = '0;
    #1 check("reset", outs(), 15'h7800);
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  // One pipeline cycle: drive, compare against the model, then advance the model past the edge.
  task automatic run(input logic [4:0] r1, r2, wr, input logic we, br, mem, ack);
    bit req, st, f1, f2;
    @(negedge clk);
    id_reg1 = r1; id_reg2 = r2; wb_Wreg = wr; wb_Wreg_en = we;
    id_branch_tkn = br; exmem_mem_en = mem; dmem_ack = ack;
    #1;
    req = !m_err && (m_busy || mem);
    st = m_err || (req && !ack);
    f1 = we && wr == r1 && r1 != 0;
    f2 = we && wr == r2 && r2 != 0;
    exp_v = {~st, ~st, ~st, ~st, req, br && !st, f1, f2, m_x1, m_x2, m_err, 4'(m_cnt)};
    act_v = outs();
    check("model", act_v, exp_v);
    @(posedge clk);
    if (!m_err) begin
      if (req && !ack) begin
        m_busy = 1;
        m_age++;
        if (m_age == TO + 1) m_err = 1;
      end else begin
        m_busy = 0;
        m_age = 0;
      end
    end
    if (st) m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
    else begin
      m_x1 = f1; m_x2 = f2;
      exmem_reg1 = r1; exmem_reg2 = r2;
    end
  endtask

  initial begin
    //            r1 r2 wr we br mem ack  st req fl f1 f2 x1 x2 er cnt
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{5, 0, 5, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{3, 7, 7, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 1, 0, 3};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0, 3};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0, 4};
    tbl[10] = '{0, 0, 0, 0, 1, 1, 1,   0, 1, 1, 0, 0, 0, 0, 0, 5};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 5};

    model_reset();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run(tbl[i].r1, tbl[i].r2, tbl[i].wr, tbl[i].we, tbl[i].br, tbl[i].mem, tbl[i].ack);
      check($sformatf("vec%0d", i), act_v,
            {~tbl[i].st, ~tbl[i].st, ~tbl[i].st, ~tbl[i].st, tbl[i].req, tbl[i].fl,
             tbl[i].f1, tbl[i].f2, tbl[i].x1, tbl[i].x2, tbl[i].er, tbl[i].cnt});
    end

    // Timeout: request never acked, ERR on the 17th cycle after the request starts.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      run(0, 0, 0, 0, 0, 1, 0);
      if (i == 16) check("pre_err_req_err", {act_v[10], act_v[4]}, 2'b10);
      if (i == 17) check("err_entry_req_err", {act_v[10], act_v[4]}, 2'b01);
    end
    check("stall_cnt_sat", act_v[3:0], 4'd15);
    for (int i = 0; i < 3; i++) begin
      run(0, 0, 0, 0, 1, 1, 1);
      check("late_ack_pc_req_err", {act_v[14], act_v[10], act_v[9], act_v[4]}, 4'b0001);
    end
    do_reset();

    // Async reset while in MEM_WAIT drops dmem_req without a clock edge.
    run(0, 0, 0, 0, 0, 1, 0);
    run(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    zero_inputs();
    #2 check("mem_wait_hold", outs(), 15'h0402);
    rst = 0;
    #1 check("async_rst", outs(), 15'h7800);
    @(negedge clk);
    rst = 1;
    exmem_reg1 = '0; exmem_reg2 = '0;
    model_reset();

    // Randomized traffic; segments 3 and 7 starve the memory to reach timeouts.
    for (int seg = 0; seg < 8; seg++) begin
      int ackp;
      ackp = (seg % 4 == 3) ? 2 : 20 + 20 * (seg % 4);
      do_reset();
      for (int c = 0; c < 250; c++)
        run(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < ackp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
